// File: rtl/aes128_dec_core.sv
// Iterative AES-128 decryption core (straight inverse cipher, one round per clock).
// Key schedule is expanded into 11 stored round keys before the rounds run.
// Optional feature: define AES_KEY_CACHE_EN to reuse the last expanded key
// schedule when the next block arrives with the same cipher key.

package aes128_dec_pkg;
    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = product of a^(2^k), k=1..7; maps 0 to 0
    function automatic logic [7:0] gf_inv(logic [7:0] a);
        logic [7:0] sq, p;
        sq = a;
        p  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            p  = gmul(p, sq);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix(logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction
endpackage

// Bytewise forward (enc_or_dec=1) or inverse (enc_or_dec=0) S-box
module sub_bytes #(
    parameter int NB = 16
) (
    input  logic [8*NB-1:0] din,
    input  logic            enc_or_dec,
    output logic [8*NB-1:0] dout
);
    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign dout[8*i +: 8] = enc_or_dec ? aes128_dec_pkg::sbox(din[8*i +: 8])
                                           : aes128_dec_pkg::inv_sbox(din[8*i +: 8]);
    end
endmodule

// One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns
module round_dec (
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         mix_col,
    output logic [127:0] result
);
    logic [127:0] sr, sb, ak;

    // Row r of column c takes row r from column (c - r) mod 4 (rotate right)
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = state[127-8*(4*((c-r)&3)+r) -: 8];
    end

    sub_bytes #(.NB(16)) u_inv_sub (.din(sr), .enc_or_dec(1'b0), .dout(sb));

    assign ak = sb ^ rk;

    // Last round skips InvMixColumns
    always_comb begin
        result = ak;
        if (mix_col)
            for (int c = 0; c < 4; c++)
                result[127-32*c -: 32] = aes128_dec_pkg::inv_mix(ak[127-32*c -: 32]);
    end
endmodule

module aes128_dec_core #(
    parameter int NR     = 10,
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] ct_i,
    input  logic [DATA_W-1:0] key_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] pt_o,
    output logic              busy_o
);
    if (NR != 10 || DATA_W != 128) begin : g_param_check
        $error("aes128_dec_core supports only NR=10 and DATA_W=128");
    end

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, DONE} fsm_t;

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic [127:0] st;
    logic [127:0] rk [0:10];
    logic [127:0] kprev, knext, rnd_out;
    logic [31:0]  kword, ksub, ktmp;
`ifdef AES_KEY_CACHE_EN
    logic         cache_vld;
`endif

    // Key schedule step: rnd selects which round key is being produced
    assign kprev = rk[rnd - 4'd1];
    assign kword = {kprev[23:0], kprev[31:24]};

    sub_bytes #(.NB(4)) u_key_sub (.din(kword), .enc_or_dec(1'b1), .dout(ksub));

    // Chain the four words of the next round key
    always_comb begin
        ktmp          = ksub ^ {rcon, 24'h0};
        knext[127:96] = kprev[127:96] ^ ktmp;
        knext[95:64]  = kprev[95:64]  ^ knext[127:96];
        knext[63:32]  = kprev[63:32]  ^ knext[95:64];
        knext[31:0]   = kprev[31:0]   ^ knext[63:32];
    end

    // Round r consumes rk[10-r]; the tenth round omits InvMixColumns
    round_dec u_round (
        .state   (st),
        .rk      (rk[4'd10 - rnd]),
        .mix_col (rnd != 4'd10),
        .result  (rnd_out)
    );

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm         <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            pt_o        <= '0;
            rnd         <= 4'd0;
            rcon        <= 8'h01;
`ifdef AES_KEY_CACHE_EN
            cache_vld   <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE: if (in_valid_i) begin
                    st         <= ct_i;
                    rnd        <= 4'd1;
                    rcon       <= 8'h01;
                    in_ready_o <= 1'b0;
                    busy_o     <= 1'b1;
`ifdef AES_KEY_CACHE_EN
                    if (cache_vld && key_i == rk[0]) begin
                        fsm <= INIT;
                    end else begin
                        rk[0]     <= key_i;
                        cache_vld <= 1'b0;
                        fsm       <= KEXP;
                    end
`else
                    rk[0] <= key_i;
                    fsm   <= KEXP;
`endif
                end
                KEXP: begin
                    rk[rnd] <= knext;
                    rcon    <= aes128_dec_pkg::xtime(rcon);
                    if (rnd == 4'd10) begin
                        fsm <= INIT;
`ifdef AES_KEY_CACHE_EN
                        cache_vld <= 1'b1;
`endif
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                INIT: begin
                    st  <= st ^ rk[10];
                    rnd <= 4'd1;
                    fsm <= ROUND;
                end
                ROUND: begin
                    st <= rnd_out;
                    if (rnd == 4'd10) begin
                        pt_o        <= rnd_out;
                        out_valid_o <= 1'b1;
                        fsm         <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: if (out_ready_i) begin
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    busy_o      <= 1'b0;
                    fsm         <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_dec_core.sv
// Directed bench for aes128_dec_core with an expected-plaintext scoreboard.
// Honours AES_KEY_CACHE_EN through a small model of the key cache flag.
module tb_aes128_dec_core;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic [127:0] ct, key;
    logic         in_ready_o, out_valid_o, busy_o;
    logic [127:0] pt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_lat = 21;
    int n_acc = 0;
    int n_out = 0;
    bit prev_ov = 1'b0;
    bit last_acc = 1'b0;
    logic [127:0] exp_pt;
    logic [127:0] q [$];
`ifdef AES_KEY_CACHE_EN
    bit           m_cv = 1'b0;
    bit           m_pend = 1'b0;
    int           m_set_at = 0;
    logic [127:0] m_key = '0;
`endif

    aes128_dec_core dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .ct_i        (ct),
        .key_i       (key),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .pt_o        (pt_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes due at the coming edge, then sample at edge+1
    task automatic step();
        logic acc, hs;
        acc = in_valid && in_ready_o && !rst;
        hs  = out_valid_o && out_ready && !rst;
        last_acc = acc;
        if (hs) begin
            chk("no_accept_on_output_edge", 128'(in_ready_o), 128'(0));
            if (q.size() == 0) chk("unexpected_output", 128'(out_valid_o), 128'(0));
            else chk("plaintext", pt_o, q.pop_front());
            n_out++;
        end
        if (acc) begin
            q.push_back(exp_pt);
            acc_cyc = cyc + 1;
            n_acc++;
`ifdef AES_KEY_CACHE_EN
            if (m_cv && key == m_key) exp_lat = 11;
            else begin
                exp_lat  = 21;
                m_cv     = 1'b0;
                m_key    = key;
                m_pend   = 1'b1;
                m_set_at = cyc + 11;
            end
`else
            exp_lat = 21;
`endif
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            q.delete();
`ifdef AES_KEY_CACHE_EN
            m_cv   = 1'b0;
            m_pend = 1'b0;
`endif
        end
`ifdef AES_KEY_CACHE_EN
        if (m_pend && cyc >= m_set_at) begin
            m_cv   = 1'b1;
            m_pend = 1'b0;
        end
`endif
        if (out_valid_o && !prev_ov && !rst)
            chk("latency", 128'(cyc - acc_cyc), 128'(exp_lat));
        prev_ov = out_valid_o;
    endtask

    task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p);
        ct = c; key = k; exp_pt = p; in_valid = 1'b1;
        for (int n = 0; n < 100 && !in_ready_o; n++) step();
        chk("in_ready_before_send", 128'(in_ready_o), 128'(1));
        step();
        in_valid = 1'b0; ct = '0; key = '0;
    endtask

    task automatic wait_out(input int budget);
        for (int n = 0; n < budget && !out_valid_o; n++) step();
        chk("out_valid_reached", 128'(out_valid_o), 128'(1));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid_o), 128'(0));
        chk({tag, "_in_ready"}, 128'(in_ready_o), 128'(1));
        chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    endtask

    initial begin
        bit sel;
        int a0, o0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ct = '0; key = '0; exp_pt = '0;

        // Reset state
        repeat (3) step();
        chk_idle("reset");
        chk("reset_pt", pt_o, 128'h0);
        rst = 1'b0;
        step();

        // FIPS-197 C.1, sink ready before completion
        out_ready = 1'b1;
        send(C1, K1, P1);
        wait_out(40);
        step();
        chk_idle("after_t1");

        // FIPS-197 B with last round key check
        send(C2, K2, P2);
        wait_out(40);
        chk("rk10", dut.rk[10], RK10_2);
        step();

        // Backpressure: output held, new requests ignored
        out_ready = 1'b0;
        send(C1, K1, P1);
        wait_out(40);
        for (int i = 0; i < 50; i++) begin
            in_valid = (i % 3 == 0); ct = C2; key = K2;
            step();
            chk("bp_pt", pt_o, P1);
            chk("bp_out_valid", 128'(out_valid_o), 128'(1));
            chk("bp_in_ready", 128'(in_ready_o), 128'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk_idle("bp_release");
        chk("bp_queue_empty", 128'(q.size()), 128'(0));

        // Reset in the middle of round 5
        send(C1, K1, P1);
        repeat (exp_lat == 21 ? 15 : 5) step();
        chk("pre_reset_busy", 128'(busy_o), 128'(1));
        rst = 1'b1;
        step();
        chk_idle("mid_reset");
        chk("mid_reset_pt", pt_o, 128'h0);
        rst = 1'b0;
        step();
        send(C1, K1, P1);
        wait_out(40);
        step();

        // Same key twice, then a different key
        send(C1, K1, P1);
        wait_out(40);
        step();
        send(C1, K1, P1);
        wait_out(40);
        step();
        send(C2, K2, P2);
        wait_out(40);
        step();

        // in_valid held high with alternating vectors
        a0 = n_acc; o0 = n_out; sel = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && n_out - o0 < 4; n++) begin
            ct = sel ? C2 : C1; key = sel ? K2 : K1; exp_pt = sel ? P2 : P1;
            step();
            if (last_acc) sel = ~sel;
        end
        in_valid = 1'b0;
        chk("stream_outputs", 128'(n_out - o0), 128'(4));
        chk("stream_accepts", 128'(n_acc - a0), 128'(4));
        chk("stream_queue_empty", 128'(q.size()), 128'(0));
        step();
        chk_idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
